// File: rtl/jpeg_frame_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_frame_wrapper
// Purpose  : Wraps the jfpjc entropy-coded byte stream into a complete JPEG
//            file stream. It sends the fixed header bytes read from a header
//            EBR, then the payload (optionally stuffed 0xFF -> 0xFF,0x00),
//            then the EOI marker (0xFF,0xD9). Payload is buffered in a FIFO
//            because jfpjc cannot be stalled. Output is a valid/ready source.
// Ports    : clock, nreset                 - clock, async active-low reset
//            frame_start, frame_end        - frame control pulses
//            in_valid, in_data             - payload bytes from jfpjc
//            header_ebr_raddr/ren/rclk     - header EBR read port
//            header_ebr_dout               - header EBR data (1-clock latency)
//            out_valid, out_ready, out_data- output byte stream
//            busy, overflow                - status (overflow is sticky)
// Revision : 1.0 - initial release
// ============================================================================
module jpeg_frame_wrapper #(
    parameter int HEADER_LEN = 328,
    parameter int FIFO_DEPTH = 64,
    parameter bit STUFF_FF   = 1'b1
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       frame_start,
    input  logic       frame_end,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic [8:0] header_ebr_raddr,
    output logic       header_ebr_ren,
    output logic       header_ebr_rclk,
    input  logic [7:0] header_ebr_dout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       overflow
);

    localparam int         c_PW      = $clog2(FIFO_DEPTH);
    localparam logic [8:0] c_HDR_LEN = 9'(HEADER_LEN);

    // Each non-idle state names what the output register is being filled
    // with: STUFF loads the 0x00, EOI_FF holds 0xFF and loads 0xD9 next,
    // EOI_D9 holds 0xD9 until it is accepted.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_STUFF   = 3'd3,
        S_EOI_FF  = 3'd4,
        S_EOI_D9  = 3'd5
    } state_t;

    state_t        r_state, w_state_nxt;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [c_PW:0] r_wr_ptr, r_rd_ptr;
    logic          w_full, w_empty, w_push, w_pop;
    logic [7:0]    w_fifo_rdata;

    logic          r_out_valid;
    logic [7:0]    r_out_data;
    logic [8:0]    r_raddr;
    logic          r_pend;        // EBR read issued last cycle, data on dout now
    logic          r_skid_vld;
    logic [7:0]    r_skid;
    logic          r_end_seen;
    logic          r_overflow;

    logic          w_accept, w_slot, w_start, w_ren, w_load, w_take_skid;
    logic          w_hdr_done;
    logic [7:0]    w_load_data;

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[c_PW] != r_rd_ptr[c_PW]) &&
                          (r_wr_ptr[c_PW-1:0] == r_rd_ptr[c_PW-1:0]);
    assign w_push       = in_valid && !w_full;
    assign w_fifo_rdata = r_mem[r_rd_ptr[c_PW-1:0]];

    assign w_accept = r_out_valid && out_ready;
    assign w_slot   = !r_out_valid || out_ready;
    assign w_start  = (r_state == S_IDLE) && frame_start;

    always_comb begin
        w_state_nxt = r_state;
        w_ren       = 1'b0;
        w_load      = 1'b0;
        w_load_data = 8'h00;
        w_pop       = 1'b0;
        w_take_skid = 1'b0;
        w_hdr_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_start) w_state_nxt = S_HEADER;
            end
            S_HEADER: begin
                // Bytes held (output reg + skid) plus the read in flight may
                // not exceed two after this cycle, so a stalled sink never
                // loses an EBR word, yet a ready sink sees one byte per clock.
                w_ren = (r_raddr != c_HDR_LEN) &&
                        (({1'b0, r_out_valid} + {1'b0, r_skid_vld} + {1'b0, r_pend})
                         <= (2'd1 + {1'b0, w_accept}));
                if (w_slot && (r_skid_vld || r_pend)) begin
                    w_load      = 1'b1;
                    w_take_skid = r_skid_vld;
                    w_load_data = r_skid_vld ? r_skid : header_ebr_dout;
                end
                w_hdr_done = (r_raddr == c_HDR_LEN) && !r_pend && !r_skid_vld && w_accept;
                if (w_hdr_done) w_state_nxt = S_PAYLOAD;
            end
            S_PAYLOAD: begin
            end
            S_STUFF: begin
                if (w_slot) begin
                    w_load      = 1'b1;
                    w_load_data = 8'h00;
                    w_state_nxt = S_PAYLOAD;
                end
            end
            S_EOI_FF: begin
                if (w_slot) begin
                    w_load      = 1'b1;
                    w_load_data = 8'hD9;
                    w_state_nxt = S_EOI_D9;
                end
            end
            S_EOI_D9: begin
                if (w_accept) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Payload selection also runs on the cycle the last header byte is
        // accepted, so the first payload byte follows without a bubble.
        if ((r_state == S_PAYLOAD) || w_hdr_done) begin
            if (w_slot) begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_load_data = w_fifo_rdata;
                    w_state_nxt = (STUFF_FF && (w_fifo_rdata == 8'hFF)) ? S_STUFF : S_PAYLOAD;
                end else if (r_end_seen) begin
                    w_load      = 1'b1;
                    w_load_data = 8'hFF;
                    w_state_nxt = S_EOI_FF;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_raddr     <= 9'd0;
            r_pend      <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_skid      <= 8'h00;
            r_end_seen  <= 1'b0;
            r_overflow  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_load_data;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end

            r_pend <= w_ren;
            if (w_start)    r_raddr <= 9'd0;
            else if (w_ren) r_raddr <= r_raddr + 9'd1;

            // EBR data not taken straight into the output register is parked.
            if (r_pend && !(w_load && !w_take_skid)) begin
                r_skid_vld <= 1'b1;
                r_skid     <= header_ebr_dout;
            end else if (w_take_skid) begin
                r_skid_vld <= 1'b0;
            end

            if (w_start)                                 r_end_seen <= 1'b0;
            else if (frame_end && (r_state != S_IDLE))   r_end_seen <= 1'b1;

            if (in_valid && w_full) r_overflow <= 1'b1;
            else if (w_start)       r_overflow <= 1'b0;

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // FIFO storage carries no reset; the pointers define its contents.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr[c_PW-1:0]] <= in_data;
    end

    assign header_ebr_raddr = r_raddr;
    assign header_ebr_ren   = w_ren;
    assign header_ebr_rclk  = clock;
    assign out_valid        = r_out_valid;
    assign out_data         = r_out_data;
    assign busy             = (r_state != S_IDLE);
    assign overflow         = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_frame_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_frame_wrapper
// Purpose  : Self-checking bench for jpeg_frame_wrapper. A behavioural model
//            builds each expected JPEG byte stream (header, stuffed payload,
//            EOI) from queues; the captured output is compared against it.
//            A second instance covers the unstuffed configuration.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_jpeg_frame_wrapper;

    localparam int c_HLEN = 328;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    logic       nreset, frame_start, frame_end, in_valid, out_ready;
    logic [7:0] in_data, ebr_dout, out_data;
    logic [8:0] ebr_raddr;
    logic       ebr_ren, ebr_rclk, out_valid, busy, overflow;

    logic       b_frame_start, b_frame_end, b_in_valid, b_out_ready;
    logic [7:0] b_in_data, b_ebr_dout, b_out_data;
    logic [8:0] b_ebr_raddr;
    logic       b_ebr_ren, b_ebr_rclk, b_out_valid, b_busy, b_overflow;

    jpeg_frame_wrapper #(.HEADER_LEN(c_HLEN), .FIFO_DEPTH(64), .STUFF_FF(1'b1)) u_dut (
        .clock(clock), .nreset(nreset), .frame_start(frame_start), .frame_end(frame_end),
        .in_valid(in_valid), .in_data(in_data), .header_ebr_raddr(ebr_raddr),
        .header_ebr_ren(ebr_ren), .header_ebr_rclk(ebr_rclk), .header_ebr_dout(ebr_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .overflow(overflow));

    jpeg_frame_wrapper #(.HEADER_LEN(c_HLEN), .FIFO_DEPTH(64), .STUFF_FF(1'b0)) u_dut_ns (
        .clock(clock), .nreset(nreset), .frame_start(b_frame_start), .frame_end(b_frame_end),
        .in_valid(b_in_valid), .in_data(b_in_data), .header_ebr_raddr(b_ebr_raddr),
        .header_ebr_ren(b_ebr_ren), .header_ebr_rclk(b_ebr_rclk), .header_ebr_dout(b_ebr_dout),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .busy(b_busy), .overflow(b_overflow));

    // Header EBR models: content is address LSBs XOR a per-frame key.
    logic [7:0] hdr_key = 8'h00;
    always @(posedge clock) if (ebr_ren)   ebr_dout   <= ebr_raddr[7:0] ^ hdr_key;
    always @(posedge clock) if (b_ebr_ren) b_ebr_dout <= b_ebr_raddr[7:0];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output capture and stall-stability monitor.
    byte unsigned got_q[$];
    byte unsigned b_got_q[$];
    int           cyc = 0, first_cyc = 0, last_cyc = 0;
    logic         prev_stall = 1'b0;
    logic [7:0]   prev_data  = 8'h00;

    always @(negedge clock) begin
        cyc++;
        if (!nreset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", {24'd0, out_data}, {24'd0, prev_data});
            end
            if (out_valid && out_ready) begin
                if (got_q.size() == 0) first_cyc = cyc;
                last_cyc = cyc;
                got_q.push_back(out_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (b_out_valid && b_out_ready) b_got_q.push_back(b_out_data);
        end
    end

    // out_ready driver: 0 = held low, 1 = held high, 2 = random 50%.
    int ready_mode = 1;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference model: the JPEG file stream the wrapper must produce.
    task automatic build_exp(input byte unsigned pay[$], input bit stuff,
                             input logic [7:0] key, output byte unsigned exp_q[$]);
        exp_q.delete();
        for (int i = 0; i < c_HLEN; i++) exp_q.push_back(8'(i) ^ key);
        foreach (pay[i]) begin
            exp_q.push_back(pay[i]);
            if (stuff && pay[i] == 8'hFF) exp_q.push_back(8'h00);
        end
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hD9);
    endtask

    task automatic compare_stream(input string tag, input byte unsigned got[$],
                                  input byte unsigned exp[$]);
        int nm = 0;
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            if (got[i] != exp[i]) begin
                if (nm == 0) $display("  %s first diff at byte %0d: got %02h exp %02h", tag, i, got[i], exp[i]);
                nm++;
            end
        end
        check({tag, "_bytes_diff"}, nm, 0);
    endtask

    task automatic pulse_start();
        @(posedge clock); #1 frame_start = 1'b1;
        @(posedge clock); #1 frame_start = 1'b0;
    endtask

    task automatic pulse_end();
        @(posedge clock); #1 frame_end = 1'b1;
        @(posedge clock); #1 frame_end = 1'b0;
    endtask

    task automatic drive_byte(input byte unsigned b);
        @(posedge clock); #1 in_valid = 1'b1; in_data = b;
        @(posedge clock); #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clock);
        while (busy && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_frame(input string tag, input byte unsigned pay[$],
                             input int rmode, input logic [7:0] key);
        byte unsigned exp_q[$];
        hdr_key    = key;
        ready_mode = rmode;
        got_q.delete();
        pulse_start();
        check({tag, "_ovf_clr"}, {31'd0, overflow}, 32'd0);
        foreach (pay[i]) begin
            repeat ($urandom_range(0, 2)) @(posedge clock);
            drive_byte(pay[i]);
        end
        pulse_end();
        wait_idle(tag);
        build_exp(pay, 1'b1, key, exp_q);
        compare_stream(tag, got_q, exp_q);
    endtask

    initial begin
        byte unsigned pay[$];
        byte unsigned exp_q[$];
        int n;

        nreset = 1'b0; frame_start = 1'b0; frame_end = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        b_frame_start = 1'b0; b_frame_end = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00;
        b_out_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_raddr", {23'd0, ebr_raddr}, 32'd0);
        check("rst_ren", {31'd0, ebr_ren}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        @(posedge clock); #1 nreset = 1'b1;

        // Header only, continuous ready: no gaps across header and EOI.
        pay.delete();
        run_frame("t1_hdr", pay, 1, 8'h00);
        check("t1_gapless", last_cyc - first_cyc, c_HLEN + 1);

        // Payload containing 0xFF, continuous ready.
        pay = '{8'h12, 8'hFF, 8'h34};
        run_frame("t2_stuff", pay, 1, 8'h00);

        // Same payload, randomly stalled sink.
        run_frame("t4_stall", pay, 2, 8'h00);

        // Random frames with random header content and stalls.
        for (int f = 0; f < 3; f++) begin
            pay.delete();
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++)
                pay.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
            run_frame($sformatf("rand%0d", f), pay, 2, 8'($urandom));
        end

        // Overflow: sink stalled while 70 bytes arrive into a 64-deep FIFO.
        hdr_key = 8'h00; ready_mode = 0; got_q.delete(); pay.delete();
        pulse_start();
        for (int i = 0; i < 70; i++) begin
            pay.push_back(8'($urandom));
            drive_byte(pay[i]);
        end
        @(negedge clock);
        check("t5_ovf_set", {31'd0, overflow}, 32'd1);
        pulse_end();
        ready_mode = 1;
        wait_idle("t5_ovf");
        pay = pay[0:63];
        build_exp(pay, 1'b1, 8'h00, exp_q);
        compare_stream("t5_ovf", got_q, exp_q);
        check("t5_ovf_sticky", {31'd0, overflow}, 32'd1);
        pay = '{8'hFF, 8'h01};
        run_frame("t5_next", pay, 1, 8'h00);

        // Reset in the middle of the payload phase.
        hdr_key = 8'h00; ready_mode = 1; got_q.delete(); pay.delete();
        pulse_start();
        for (int i = 0; i < 30; i++) drive_byte(8'($urandom));
        n = 0;
        while (got_q.size() < c_HLEN + 3 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check("t6_in_payload", {31'd0, (got_q.size() >= c_HLEN + 3)}, 32'd1);
        @(posedge clock); #3 nreset = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clock);
        #1 nreset = 1'b1;
        pay = '{8'h55, 8'hFF};
        run_frame("t6_restart", pay, 2, 8'h00);

        // Unstuffed instance: FF,FF passes through unmodified.
        b_got_q.delete();
        @(posedge clock); #1 b_frame_start = 1'b1;
        @(posedge clock); #1 b_frame_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1 b_in_valid = 1'b1; b_in_data = 8'hFF;
            @(posedge clock); #1 b_in_valid = 1'b0;
        end
        @(posedge clock); #1 b_frame_end = 1'b1;
        @(posedge clock); #1 b_frame_end = 1'b0;
        n = 0;
        @(negedge clock);
        while (b_busy && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check("t3_idle", {31'd0, b_busy}, 32'd0);
        pay = '{8'hFF, 8'hFF};
        build_exp(pay, 1'b0, 8'h00, exp_q);
        compare_stream("t3_nostuff", b_got_q, exp_q);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
